// File: rtl/wb_cas_arbiter.sv
// Round-robin arbiter that locks one wb_cas_fsm slave to a single Wishbone master
// for a whole four-access CAS sequence (three writes, then one read).
module wb_cas_arbiter #(
    parameter int PORTS = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [PORTS*32-1:0] m_adr_i,
    input  logic [PORTS*32-1:0] m_dat_i,
    input  logic [PORTS*4-1:0]  m_sel_i,
    input  logic [PORTS-1:0]    m_we_i,
    input  logic [PORTS-1:0]    m_cyc_i,
    input  logic [PORTS-1:0]    m_stb_i,
    output logic [31:0]         m_dat_o,
    output logic [PORTS-1:0]    m_ack_o,
    output logic [PORTS-1:0]    m_err_o,
    output logic [PORTS-1:0]    m_rty_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    input  logic                s_ack_i,
    input  logic [31:0]         s_dat_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    output logic                busy_o,
    output logic [ID_W-1:0]     owner_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] last_q, last_d;

    logic [PORTS-1:0] req;
    logic [31:0]      o_adr, o_dat;
    logic [3:0]       o_sel;
    logic             o_we, o_cyc, o_req;
    logic             locked, ok, fwd;
    logic [ID_W-1:0]  pick;
    logic             found;
    int               idx;

    assign req    = m_cyc_i & m_stb_i;
    assign locked = (state_q == ST_LOCKED);

    // Owner's request fields, selected by the registered owner index.
    always_comb begin
        o_adr = '0;
        o_dat = '0;
        o_sel = '0;
        o_we  = 1'b0;
        o_cyc = 1'b0;
        o_req = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (owner_q == ID_W'(p)) begin
                o_adr = m_adr_i[32*p +: 32];
                o_dat = m_dat_i[32*p +: 32];
                o_sel = m_sel_i[4*p +: 4];
                o_we  = m_we_i[p];
                o_cyc = m_cyc_i[p];
                o_req = req[p];
            end
        end
    end

    // Phases 0..2 must be writes, phase 3 must be the read of the old value.
    assign ok  = (phase_q == 2'd3) ? ~o_we : o_we;
    assign fwd = locked & o_req & ok;

    // Search starts just after the previous owner, so the releasing master goes last.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = (int'(last_q) + k) % PORTS;
            if (!found && req[idx[ID_W-1:0]]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            owner_q <= '0;
            last_q  <= ID_W'(PORTS - 1);
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    owner_d = pick;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (s_ack_i && fwd) begin
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        last_d  = owner_q;
                        state_d = ST_IDLE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_dat_o = s_dat_i;
        s_adr_o = o_adr;
        s_dat_o = o_dat;
        s_sel_o = o_sel;
        s_we_o  = locked & o_we;
        s_cyc_o = locked & o_cyc;
        s_stb_o = fwd;
        busy_o  = locked;
        owner_o = owner_q;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (locked) begin
            for (int p = 0; p < PORTS; p++) begin
                if (owner_q == ID_W'(p)) begin
                    m_ack_o[p] = s_ack_i;
                    m_rty_o[p] = s_rty_i;
                    m_err_o[p] = s_err_i | (o_req & ~ok);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_cas_arbiter.sv
// Bench for wb_cas_arbiter: a tb-side CAS slave, per-port Wishbone masters and a
// round-robin grant model computed from the last owner and the request set.
module tb_wb_cas_arbiter;
  localparam int PORTS = 4;
  localparam int ID_W  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [PORTS*32-1:0] m_adr, m_dat;
  logic [PORTS*4-1:0]  m_sel;
  logic [PORTS-1:0]    m_we, m_cyc, m_stb;
  logic [31:0]         m_dat_o;
  logic [PORTS-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [31:0]         s_adr_o, s_dat_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o, s_cyc_o, s_stb_o;
  logic                s_ack;
  logic [31:0]         rd_val;
  logic                s_err, s_rty;
  logic                busy_o;
  logic [ID_W-1:0]     owner_o;

  assign s_err = 1'b0;
  assign s_rty = 1'b0;

  wb_cas_arbiter #(.PORTS(PORTS), .ID_W(ID_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack), .s_dat_i(rd_val), .s_err_i(s_err), .s_rty_i(s_rty),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  // CAS slave: one-cycle registered ack per strobe, read returns rd_val.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_ack <= 1'b0;
    else        s_ack <= s_cyc_o & s_stb_o & ~s_ack;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int last_m;
  logic [31:0] exp_q[$];
  logic [31:0] pend_adr[PORTS];
  logic [31:0] pend_dat[PORTS];
  logic        pend_we[PORTS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pick(input int last, input logic [PORTS-1:0] msk);
    for (int k = 1; k <= PORTS; k++)
      if (msk[(last + k) % PORTS]) return (last + k) % PORTS;
    return -1;
  endfunction

  function automatic logic [PORTS-1:0] onehot(input int p);
    logic [PORTS-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input int p, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[p] = 1'b1;
    m_stb[p] = 1'b1;
    m_we[p]  = we;
    m_adr[32*p +: 32] = adr;
    m_dat[32*p +: 32] = dat;
    m_sel[4*p +: 4]   = 4'($urandom_range(1, 15));
  endtask

  task automatic rand_pend();
    for (int p = 0; p < PORTS; p++) begin
      pend_adr[p] = $urandom & 32'hffff_fffc;
      pend_dat[p] = $urandom;
      pend_we[p]  = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_scyc", 32'(s_cyc_o), 0);
    chk("rst_sstb", 32'(s_stb_o), 0);
    chk("rst_ack", 32'({m_ack_o, m_err_o, m_rty_o}), 0);
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_owner", 32'(owner_o), 0);
    chk("rst_swe", 32'(s_we_o), 0);
    last_m = PORTS - 1;
    rand_pend();
    exp_q.delete();
  endtask

  // Raise first-write requests on every port in msk during an idle cycle.
  task automatic start_reqs(input logic [PORTS-1:0] msk);
    for (int p = 0; p < PORTS; p++)
      if (msk[p]) drive(p, pend_we[p], pend_adr[p], pend_dat[p]);
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_nofwd", 32'(s_stb_o), 0);
    chk("idle_noack", 32'(m_ack_o), 0);
  endtask

  task automatic grant(input int exp_o);
    @(negedge clk);
    chk("grant_busy", 32'(busy_o), 1);
    chk("grant_owner", 32'(owner_o), 32'(exp_o));
  endtask

  task automatic check_quiet(input int o);
    logic [PORTS-1:0] om;
    om = onehot(o);
    chk("stall_ack", 32'(m_ack_o & ~om), 0);
    chk("no_err", 32'(m_err_o), 0);
    chk("no_rty", 32'(m_rty_o), 0);
  endtask

  task automatic access(input int o, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input bit wrong);
    bit got;
    if (wrong) begin
      drive(o, ~we, adr, dat);
      repeat (2) begin
        @(negedge clk);
        chk("err_flag", 32'(m_err_o), 32'(onehot(o)));
        chk("err_nofwd", 32'(s_stb_o), 0);
        chk("err_noack", 32'(m_ack_o), 0);
      end
      @(posedge clk);
      #1;
      m_stb[o] = 1'b0;
      return;
    end
    drive(o, we, adr, dat);
    if (we) exp_q.push_back(dat);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      check_quiet(o);
      if (m_ack_o[o]) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 1);
    if (got) begin
      chk("ack_onehot", 32'(m_ack_o), 32'(onehot(o)));
      chk("fwd_adr", s_adr_o, adr);
      chk("fwd_we", 32'(s_we_o), 32'(we));
      chk("fwd_sel", 32'(s_sel_o), 32'(m_sel[4*o +: 4]));
      chk("lock_busy", 32'(busy_o), 1);
      chk("lock_owner", 32'(owner_o), 32'(o));
      if (we) chk("fwd_dat", s_dat_o, exp_q.pop_front());
      else    chk("rd_dat", m_dat_o, rd_val);
    end
    @(posedge clk);
    #1;
    m_stb[o] = 1'b0;
    m_cyc[o] = 1'($urandom_range(0, 1));
  endtask

  // One CAS sequence by owner o; bad = phase that gets a wrong-type access first,
  // abort = phase at which reset hits, rereq = owner requests again on release.
  task automatic run_seq(input int o, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] old, input int bad, input int abort,
                         input bit rereq);
    logic [31:0] adr_k, dat_k;
    logic        we_k;
    rd_val = old;
    for (int k = 0; k < 4; k++) begin
      adr_k = (k == 0) ? pend_adr[o] : ($urandom & 32'hffff_fffc);
      dat_k = (k == 0) ? pend_dat[o] : (k == 1) ? d1 : (k == 2) ? d2 : $urandom;
      we_k  = (k != 3);
      if (k == abort) begin
        drive(o, we_k, adr_k, dat_k);
        @(negedge clk);
        chk("pre_rst_cyc", 32'(s_cyc_o), 1);
        do_reset();
        return;
      end
      if (k == bad) access(o, we_k, adr_k, dat_k, 1'b1);
      access(o, we_k, adr_k, dat_k, 1'b0);
    end
    if (rereq) begin
      pend_adr[o] = $urandom & 32'hffff_fffc;
      pend_dat[o] = $urandom;
      pend_we[o]  = 1'b1;
      drive(o, 1'b1, pend_adr[o], pend_dat[o]);
    end
    @(negedge clk);
    chk("release_busy", 32'(busy_o), 0);
    chk("release_owner", 32'(owner_o), 32'(o));
    chk("release_noack", 32'(m_ack_o), 0);
    last_m = o;
  endtask

  task automatic contend(input logic [PORTS-1:0] mask_in, input int nseq, input int rr_mode,
                         input bit rand_bad);
    logic [PORTS-1:0] msk;
    int exp_o, bad;
    bit rq;
    msk = mask_in;
    for (int s = 0; s < nseq && msk != '0; s++) begin
      exp_o = pick(last_m, msk);
      grant(exp_o);
      bad = (rand_bad && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : -1;
      rq  = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!rq) msk[exp_o] = 1'b0;
      run_seq(exp_o, $urandom, $urandom, $urandom, bad, -1, rq);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [PORTS-1:0] msk;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    rd_val = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // port 2 alone: 0x100, 0x5, 0x9, then read returning 0x5
    pend_dat[2] = 32'h100;
    start_reqs(4'b0100);
    grant(2);
    run_seq(2, 32'h5, 32'h9, 32'h5, -1, -1, 1'b0);

    // ports 0 and 1 from reset
    do_reset();
    start_reqs(4'b0011);
    contend(4'b0011, 2, 0, 1'b0);

    // ports 3 and 0, releasing owner re-requests: wrap to 3
    do_reset();
    start_reqs(4'b1001);
    contend(4'b1001, 2, 1, 1'b0);

    // read in phase 0 -> err, then normal sequence
    do_reset();
    pend_we[1] = 1'b0;
    start_reqs(4'b0010);
    grant(1);
    run_seq(1, $urandom, $urandom, $urandom, 0, -1, 1'b0);

    // write in phase 3 -> err, then the read releases
    do_reset();
    p = $urandom_range(0, PORTS - 1);
    start_reqs(onehot(p));
    grant(p);
    run_seq(p, $urandom, $urandom, $urandom, 3, -1, 1'b0);

    // reset at phase 2, then a fresh sequence
    do_reset();
    start_reqs(4'b0100);
    grant(2);
    run_seq(2, $urandom, $urandom, $urandom, -1, 2, 1'b0);
    p = $urandom_range(0, PORTS - 1);
    start_reqs(onehot(p));
    contend(onehot(p), 1, 0, 1'b0);

    // randomized contention rounds
    for (int r = 0; r < 6; r++) begin
      do_reset();
      msk = PORTS'($urandom_range(1, (1 << PORTS) - 1));
      start_reqs(msk);
      contend(msk, 10, 2, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
